// File: rtl/booth_radix4_mult_if.sv
// Start/busy handshake bundle for the radix-4 Booth multiplier.
// The master issues operands and mode; the slave returns the product with busy/done status.
interface booth_radix4_mult_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;
    logic                 done;

    modport master (
        output start, signed_mode, a, b,
        input  product, busy, done
    );

    modport slave (
        input  start, signed_mode, a, b,
        output product, busy, done
    );
endinterface

// File: rtl/booth_radix4_mult.sv
// Sequential radix-4 Booth multiplier: retires two multiplier bits per clock.
// A single datapath serves signed and unsigned modes by extending operands to WIDTH+2 bits.
module booth_radix4_mult #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    booth_radix4_mult_if.slave  bus
);
    localparam int E  = WIDTH + 2;
    localparam int N  = E / 2;
    localparam int AW = 2 * E;
    localparam int CW = $clog2(N) + 1;

    typedef enum logic {IDLE, CALC} state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       mcand_q, mcand_d;
    logic [E:0]          mplr_q, mplr_d;
    logic [AW-1:0]       acc_q, acc_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]  product_q, product_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [AW-1:0]       a_ext;
    logic [E-1:0]        b_ext;
    logic [AW-1:0]       pp;
    logic [AW-1:0]       acc_sum;

    assign a_ext = bus.signed_mode ? {{(AW-WIDTH){bus.a[WIDTH-1]}}, bus.a}
                                   : {{(AW-WIDTH){1'b0}}, bus.a};
    assign b_ext = bus.signed_mode ? {{2{bus.b[WIDTH-1]}}, bus.b}
                                   : {2'b00, bus.b};

    // The multiplicand register is pre-shifted by 2 each cycle, which supplies the 4^i weight.
    always_comb begin
        pp = '0;
        case (mplr_q[2:0])
            3'b001, 3'b010: pp = mcand_q;
            3'b011:         pp = mcand_q << 1;
            3'b100:         pp = '0 - (mcand_q << 1);
            3'b101, 3'b110: pp = '0 - mcand_q;
            default:        pp = '0;
        endcase
    end

    assign acc_sum = acc_q + pp;

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    mcand_d = a_ext;
                    mplr_d  = {b_ext, 1'b0};
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d   = acc_sum;
                mcand_d = mcand_q << 2;
                mplr_d  = mplr_q >> 2;
                cnt_d   = cnt_q + CW'(1);
                // Truncation to 2*WIDTH bits is exact because the true product always fits.
                if (cnt_q == CW'(N - 1)) begin
                    product_d = acc_sum[2*WIDTH-1:0];
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplr_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplr_q    <= mplr_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.product = product_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule
